// File: rtl/ex_wb.sv
// Execute/write-back stage feeding the rf write port; single-cycle ALU ops plus an
// optional 32-iteration shift-add multiplier enabled by defining EX_WB_MUL_EN.
//
// state | meaning
// IDLE  | ready for a new op; in_ready=1
// MUL   | iterative multiply in progress (only with EX_WB_MUL_EN)
// WB    | one-cycle write-back; w=1 unless dst==0 or op was illegal
module ex_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [4:0]  dst,
  output logic [4:0]  wn,
  output logic [31:0] wd,
  output logic        w,
  output logic        err,
  output logic        busy
);

`ifdef EX_WB_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, WB = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd2} state_t;
`endif

  state_t      state;
  logic [31:0] alu;

  always_comb begin
    alu = '0;
    case (op)
      3'd0: alu = rd1 + rd2;
      3'd1: alu = rd1 - rd2;
      3'd2: alu = rd1 & rd2;
      3'd3: alu = rd1 | rd2;
      3'd4: alu = rd1 ^ rd2;
      3'd5: alu = ($signed(rd1) < $signed(rd2)) ? 32'd1 : 32'd0;
      3'd6: alu = rd1 << rd2[4:0];
      default: alu = '0;
    endcase
  end

`ifdef EX_WB_MUL_EN
  logic [31:0] mul_a, mul_b, acc, acc_n;
  logic [4:0]  cnt, dst_q;

  assign acc_n = mul_b[0] ? (acc + mul_a) : acc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      w        <= 1'b0;
      err      <= 1'b0;
      wn       <= '0;
      wd       <= '0;
`ifdef EX_WB_MUL_EN
      mul_a    <= '0;
      mul_b    <= '0;
      acc      <= '0;
      cnt      <= '0;
      dst_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          w   <= 1'b0;
          err <= 1'b0;
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (op == 3'd7) begin
`ifdef EX_WB_MUL_EN
              mul_a <= rd1;
              mul_b <= rd2;
              acc   <= '0;
              cnt   <= '0;
              dst_q <= dst;
              state <= MUL;
`else
              // Illegal without the multiplier: take the WB slot but never write.
              wn    <= dst;
              err   <= 1'b1;
              state <= WB;
`endif
            end else begin
              wn    <= dst;
              wd    <= alu;
              w     <= (dst != 5'd0);
              state <= WB;
            end
          end
        end
`ifdef EX_WB_MUL_EN
        MUL: begin
          acc   <= acc_n;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            wn    <= dst_q;
            wd    <= acc_n;
            w     <= (dst_q != 5'd0);
            state <= WB;
          end
        end
`endif
        WB: begin
          w        <= 1'b0;
          err      <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          w        <= 1'b0;
          err      <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_wb.sv
// Scoreboard bench for ex_wb: the driver pushes expected write-backs at accept,
// a negedge monitor pops and compares whenever w or err is presented.
module tb_ex_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] rd1, rd2;
  logic [4:0]  dst;
  logic [4:0]  wn;
  logic [31:0] wd;
  logic        w, err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        w;
    logic        err;
    logic [4:0]  wn;
    logic [31:0] wd;
    int          cyc;
  } exp_t;

  exp_t q[$];

  ex_wb dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd1(rd1), .rd2(rd2), .dst(dst),
    .wn(wn), .wd(wd), .w(w), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef EX_WB_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint signed sa, sb;
    longint unsigned prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    prod = longint'(a) * longint'(b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a * (32'd1 << b[4:0]);
      default: return prod[31:0];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Returns the accept edge index in e (or -1 on timeout); leaves the bench at the negedge after accept.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input bit push, output int e);
    int n;
    exp_t x;
    n = 0;
    e = -1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%b want=1", in_ready);
      return;
    end
    op = o; rd1 = a; rd2 = b; dst = d; in_valid = 1'b1;
    e = cyc + 1;
    if (push) begin
      if (o == 3'd7 && !MUL_EN) begin
        x.w = 1'b0; x.err = 1'b1; x.wn = d; x.wd = '0; x.cyc = e;
        q.push_back(x);
      end else if (d != 5'd0) begin
        x.w = 1'b1; x.err = 1'b0; x.wn = d; x.wd = model(o, a, b);
        x.cyc = (o == 3'd7) ? e + 32 : e;
        q.push_back(x);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    op = $urandom; rd1 = $urandom; rd2 = $urandom; dst = $urandom;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL wb_missing expected at cyc=%0d now=%0d", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (w || err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_wb cyc=%0d w=%b err=%b wn=%0d wd=%h want none", cyc, w, err, wn, wd);
        end else begin
          exp_t x;
          x = q.pop_front();
          if (w !== x.w || err !== x.err || cyc != x.cyc || (x.w && (wn !== x.wn || wd !== x.wd))) begin
            errors++;
            $display("FAIL wb_check got w=%b err=%b wn=%0d wd=%h cyc=%0d want w=%b err=%b wn=%0d wd=%h cyc=%0d",
                     w, err, wn, wd, cyc, x.w, x.err, x.wn, x.wd, x.cyc);
          end
        end
      end
    end
  end

  initial begin
    int e, n;
    logic [2:0] ro;
    reset = 1'b1; in_valid = 1'b0; op = '0; rd1 = '0; rd2 = '0; dst = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_w", {31'd0, w}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wn", {27'd0, wn}, 32'd0);
    check("rst_wd", wd, 32'd0);
    reset = 1'b0;

    issue(3'd0, 32'd5, 32'd7, 5'd3, 1'b1, e);
    check("add_w", {31'd0, w}, 32'd1);
    check("add_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("add_w_after", {31'd0, w}, 32'd0);
    check("add_ready_back", {31'd0, in_ready}, 32'd1);
    check("add_wd_hold", wd, 32'd12);

    issue(3'd1, 32'd0, 32'd1, 5'd4, 1'b1, e);
    issue(3'd5, 32'hFFFFFFFF, 32'd1, 5'd5, 1'b1, e);
    issue(3'd6, 32'd1, 32'h25, 5'd6, 1'b1, e);

    issue(3'd0, 32'd1, 32'd1, 5'd0, 1'b1, e);
    check("dst0_busy", {31'd0, busy}, 32'd1);
    check("dst0_w", {31'd0, w}, 32'd0);

    if (MUL_EN) begin
      issue(3'd7, 32'd1234, 32'd5678, 5'd9, 1'b1, e);
      n = 0;
      while (!in_ready && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("mul_ready_low_cycles", n, 32'd33);
      issue(3'd7, 32'hFFFFFFFF, 32'd2, 5'd10, 1'b1, e);

      issue(3'd7, 32'd77, 32'd99, 5'd11, 1'b0, e);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mulrst_busy", {31'd0, busy}, 32'd0);
      check("mulrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mulrst_w", {31'd0, w}, 32'd0);
      repeat (40) @(negedge clk);
    end else begin
      issue(3'd7, 32'd3, 32'd4, 5'd7, 1'b1, e);
      check("illegal_err", {31'd0, err}, 32'd1);
      check("illegal_w", {31'd0, w}, 32'd0);
      issue(3'd0, 32'd100, 32'd23, 5'd8, 1'b1, e);
    end

    for (int i = 0; i < 150; i++) begin
      ro = $urandom_range(0, 7);
      if (MUL_EN && ro == 3'd7 && ($urandom_range(0, 3) != 0)) ro = $urandom_range(0, 6);
      issue(ro, $urandom, (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
            5'($urandom_range(0, 31)), 1'b1, e);
    end

    repeat (40) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
